// File: rtl/frame_buffer_ring.sv
`default_nettype none
// ============================================================================
// Module  : frame_buffer_ring
// Brief   : N-way frame buffer ring (2..4 banks) with latest-frame-wins queue
//           and writer back-pressure. FRAME_BUFFER_STATS_EN enables counters.
// Revision: 1.0
// ============================================================================
module frame_buffer_ring #(
  parameter int NUM_BUFS = 3,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_done,
  output logic              write_ready,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] read_data,
  input  logic              disp_done,
  output logic [1:0]        disp_buf,
  output logic [1:0]        write_buf,
  output logic              swap,
  output logic [15:0]       drop_count,
  output logic [15:0]       repeat_count
);

  localparam int c_depth = 1 << ADDR_W;

  if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_cfg
    $fatal(1, "frame_buffer_ring: NUM_BUFS must be in 2..4");
  end

  typedef enum logic [0:0] {
    ST_WRITING   = 1'b0,
    ST_WAIT_FREE = 1'b1
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_disp_idx, w_disp_idx;
  logic [1:0]  r_write_idx, w_write_idx;
  logic [1:0]  r_pend_idx, w_pend_idx;
  logic        r_pend_valid, w_pend_valid;
  logic        r_swap, w_swap;
  logic        w_drop, w_repeat;
  logic        w_write_done;
  logic [1:0]  w_free;
  logic        w_wr_fire;
  logic [1:0]  r_rd_sel;
  logic        r_rd_valid;
  logic [DATA_W-1:0] w_bank_q [4];

  assign write_ready  = (r_state == ST_WRITING);
  assign w_wr_fire    = write_en && write_ready;
  assign w_write_done = write_done && (r_state == ST_WRITING);

  always_comb begin
    w_free = 2'd0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (2'(i) != r_disp_idx && 2'(i) != r_write_idx) w_free = 2'(i);
    end
  end

  always_comb begin
    w_state      = r_state;
    w_disp_idx   = r_disp_idx;
    w_write_idx  = r_write_idx;
    w_pend_idx   = r_pend_idx;
    w_pend_valid = r_pend_valid;
    w_swap       = 1'b0;
    w_drop       = 1'b0;
    w_repeat     = 1'b0;
    if (w_write_done && disp_done) begin
      // Freshly completed frame goes straight to display; any queued one is lost.
      w_disp_idx   = r_write_idx;
      w_write_idx  = r_disp_idx;
      w_swap       = 1'b1;
      w_drop       = r_pend_valid;
      w_pend_valid = 1'b0;
    end else if (disp_done) begin
      if (r_pend_valid) begin
        w_disp_idx   = r_pend_idx;
        w_pend_valid = 1'b0;
        w_swap       = 1'b1;
        if (r_state == ST_WAIT_FREE) w_write_idx = r_disp_idx;
        w_state      = ST_WRITING;
      end else begin
        w_repeat = 1'b1;
      end
    end else if (w_write_done) begin
      w_pend_idx   = r_write_idx;
      w_pend_valid = 1'b1;
      if (NUM_BUFS == 2) begin
        w_state = ST_WAIT_FREE;
      end else begin
        w_drop      = r_pend_valid;
        w_write_idx = w_free;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_WRITING;
      r_disp_idx   <= 2'd0;
      r_write_idx  <= 2'd1;
      r_pend_idx   <= 2'd0;
      r_pend_valid <= 1'b0;
      r_swap       <= 1'b0;
      r_rd_sel     <= 2'd0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_disp_idx   <= w_disp_idx;
      r_write_idx  <= w_write_idx;
      r_pend_idx   <= w_pend_idx;
      r_pend_valid <= w_pend_valid;
      r_swap       <= w_swap;
      r_rd_sel     <= r_disp_idx;
      r_rd_valid   <= 1'b1;
    end
  end

  // Every bank reads each cycle; the registered display index selects one whole pixel.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    if (b < NUM_BUFS) begin : g_used
      logic [DATA_W-1:0] r_mem [c_depth];
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
        if (w_wr_fire && r_write_idx == 2'(b)) r_mem[write_address] <= write_data;
        r_q <= r_mem[read_address];
      end
      assign w_bank_q[b] = r_q;
    end else begin : g_absent
      assign w_bank_q[b] = '0;
    end
  end

  assign read_data = r_rd_valid ? w_bank_q[r_rd_sel] : '0;
  assign disp_buf  = r_disp_idx;
  assign write_buf = r_write_idx;
  assign swap      = r_swap;

`ifdef FRAME_BUFFER_STATS_EN
  logic [15:0] r_drop_count, r_repeat_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_count   <= 16'd0;
      r_repeat_count <= 16'd0;
    end else begin
      if (w_drop && r_drop_count != 16'hFFFF)     r_drop_count   <= r_drop_count + 16'd1;
      if (w_repeat && r_repeat_count != 16'hFFFF) r_repeat_count <= r_repeat_count + 16'd1;
    end
  end
  assign drop_count   = r_drop_count;
  assign repeat_count = r_repeat_count;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_drop | w_repeat;
  assign drop_count     = 16'd0;
  assign repeat_count   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/frame_buffer_ring.md
# frame_buffer_ring

Parametrised N-way frame buffer for the VGA path: NUM_BUFS internal single-port-per-side RAM banks, one displayed and one written at a time, with completed frames queued for display at the next frame boundary. It generalises two-buffer ping-pong to double or triple/quad buffering. Unlike the ping-pong scheme, it adds:

- gated writes,
- writer back-pressure,
- latest-frame-wins dropping.

It sits between the draw engine (write side) and the VGA scan-out (read side).

## Interface
- NUM_BUFS, 3, number of frame banks; legal 2..4
- ADDR_W, 15, pixel address width; bank depth 2^ADDR_W
- DATA_W, 24, pixel width (RGB888)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous active-low reset
- write_en  in  1  write strobe; honoured only while write_ready=1
- write_address  in  ADDR_W  write pixel address
- write_data  in  DATA_W  write pixel data
- write_done  in  1  one-cycle pulse: current write bank holds a complete frame
- write_ready  out  1  writer may write; 0 while no free bank
- read_address  in  ADDR_W  scan-out pixel address
- read_data  out  DATA_W  pixel from display bank, registered
- disp_done  in  1  one-cycle pulse at end of displayed frame (vsync)
- disp_buf  out  2  index of bank being displayed
- write_buf  out  2  index of bank being written
- swap  out  1  one-cycle pulse when disp_buf changes
- drop_count  out  16  frames discarded unseen (saturating)
- repeat_count  out  16  frame boundaries with no new frame (saturating)

## Operation
- State registers:
  - disp_idx
  - write_idx
  - pend_idx and pend_valid (one completed, undisplayed frame)
  - writer FSM: WRITING, WAIT_FREE
- Reset values:
  - disp_idx=0, write_idx=1, pend_valid=0, FSM=WRITING
  - write_ready=1, read_data=0, swap=0, counters=0
- Write: on an edge with write_en=1 and write_ready=1, bank[write_idx][write_address] <= write_data. A write in the same cycle as write_done lands in the completing bank.
- Free bank: the lowest index that is neither disp_idx nor the bank being queued.
- write_done in WRITING, no disp_done, NUM_BUFS>=3:
  - if pend_valid, the old pending bank is discarded and drop_count increments
  - pend_idx<=write_idx, pend_valid<=1
  - write_idx<=free bank; stay WRITING
- write_done in WRITING, no disp_done, NUM_BUFS=2: pend_idx<=write_idx, pend_valid<=1, FSM->WAIT_FREE, write_ready<=0.
- write_done in WAIT_FREE: ignored.
- disp_done with pend_valid:
  - disp_idx<=pend_idx, pend_valid<=0, swap pulses
  - write_idx takes the old disp_idx only if in WAIT_FREE; FSM->WRITING, write_ready<=1
- disp_done without pend_valid: no swap; repeat_count increments.
- write_done and disp_done simultaneous (WRITING):
  - disp_idx<=write_idx, write_idx<=old disp_idx, swap pulses
  - any older pending bank is discarded; drop_count increments and pend_valid<=0
- Counters saturate at 16'hFFFF.
- NUM_BUFS outside 2..4 is a configuration error and must fail elaboration.

## Timing
- Read latency: 1 cycle. read_data at edge t+1 is bank[disp_idx@t][read_address@t].
- A swap takes effect on the read mux the cycle after disp_done. No pixel ever mixes banks.
- write_ready, write_buf, disp_buf and swap are registered; they update on the edge that samples the done pulse(s).
- A write presented in the cycle write_ready falls (same edge as write_done) is accepted. Writes while write_ready=0 are dropped silently.
- Reset asserted mid-frame returns all state to reset values immediately. RAM contents are not cleared.

## Configuration
- FRAME_BUFFER_STATS_EN defined: drop_count and repeat_count are live as described.
- FRAME_BUFFER_STATS_EN undefined: counter logic is compiled out and both ports are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then write 0xABCDEF @addr 5 to bank 1, write_done, disp_done, read addr 5 -> disp_buf=1, read_data=0xABCDEF one cycle later, swap pulsed once.
- NUM_BUFS=2: write_done without disp_done -> write_ready=0. Write 0x111111 @0 while stalled -> bank unchanged. disp_done -> write_ready=1, write_buf=0.
- NUM_BUFS=3: two write_done pulses before one disp_done -> drop_count=1, and the display shows the second frame.
- Three disp_done pulses with no write_done -> repeat_count=3, disp_buf stays 0, swap never pulses.
- write_done and disp_done in the same cycle -> disp_buf=old write_buf, write_buf=old disp_buf, pend_valid=0.
- Assert rst mid-frame with pend_valid=1 -> disp_buf=0, write_buf=1, write_ready=1, counters=0; with the macro undefined, counters read 0 throughout.
